// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC generation, inst SRAM handshake with a single
// outstanding request, a one-entry output buffer toward preDecode, and redirect
// handling from exception, ertn, branch resolve and preDecode prediction.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h1c000000,
  parameter logic [7:0]  ADEF_ECODE = 8'h08
) (
  input  logic        clk,
  input  logic        rst,
  // inst SRAM
  output logic        inst_sram_req,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  // preDecode interface
  output logic        FpD_valid,
  output logic [74:0] FpD_BUS,
  input  logic        pD_allowin,
  input  logic        pDD_fire,
  input  logic [32:0] predict_BUS,
  // redirect sources
  input  logic        predict_error,
  input  logic [31:0] br_correct_target,
  input  logic        ertn_flush,
  input  logic [31:0] era,
  input  logic        ex_en,
  input  logic [31:0] ex_entry
);

  localparam logic [1:0] S_REQ       = 2'd0;
  localparam logic [1:0] S_WAIT_ADDR = 2'd1;
  localparam logic [1:0] S_WAIT_DATA = 2'd2;
  localparam logic [1:0] S_HOLD      = 2'd3;

  logic [1:0]  state_reg,    state_next;
  logic [31:0] pc_reg,       pc_next;
  logic [31:0] req_addr_reg, req_addr_next;
  logic        buf_valid_reg, buf_valid_next;
  logic [74:0] buf_reg,      buf_next;
  // discard: an accepted request whose data must be thrown away
  logic        discard_reg,  discard_next;
  // stale: a redirect arrived while the request still waits for addr_ok
  logic        stale_reg,    stale_next;

  logic        predict_taken;
  logic [31:0] predict_target;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        handoff;
  logic        pc_aligned;
  logic        issue;
  logic [74:0] adef_entry;
  logic [74:0] inst_entry;

  assign predict_taken  = predict_BUS[32];
  assign predict_target = predict_BUS[31:0];

  // Prediction redirects only count on an actual handoff, so a stalled
  // preDecode holding predict_taken high does not refetch repeatedly.
  assign redirect = ex_en | ertn_flush | predict_error | (predict_taken & pDD_fire);

  // Redirect target selection in priority order.
  always_comb begin
    redirect_pc = predict_target;
    if (ex_en) begin
      redirect_pc = ex_entry;
    end else if (ertn_flush) begin
      redirect_pc = era;
    end else if (predict_error) begin
      redirect_pc = br_correct_target;
    end
  end

  assign handoff    = buf_valid_reg & pD_allowin;
  assign pc_aligned = (pc_reg[1:0] == 2'b00);

  // A fresh request goes out from REQ, or from HOLD in the cycle the buffer
  // drains. It is withheld on a redirect so no stale-PC request is started.
  assign issue = ~rst & ~redirect & pc_aligned &
                 ((state_reg == S_REQ) | ((state_reg == S_HOLD) & handoff));

  assign inst_sram_req  = ~rst & ((state_reg == S_WAIT_ADDR) | issue);
  assign inst_sram_addr = (state_reg == S_WAIT_ADDR) ? req_addr_reg : pc_reg;

  assign FpD_valid = buf_valid_reg;
  assign FpD_BUS   = buf_reg;

  assign adef_entry = {pc_reg, 32'h0, 1'b0, 1'b1, ADEF_ECODE, 1'b0};
  assign inst_entry = {pc_reg, inst_sram_rdata, 1'b1, 1'b0, 8'h00, 1'b0};

  // Next-state logic for the fetch FSM, buffer and flush bookkeeping.
  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    req_addr_next  = req_addr_reg;
    buf_valid_next = buf_valid_reg;
    buf_next       = buf_reg;
    discard_next   = discard_reg;
    stale_next     = stale_reg;

    case (state_reg)
      S_REQ: begin
        if (!redirect) begin
          if (!pc_aligned) begin
            // Misaligned PC: report ADEF through the buffer, no SRAM access.
            buf_valid_next = 1'b1;
            buf_next       = adef_entry;
            state_next     = S_HOLD;
          end else if (inst_sram_addr_ok) begin
            state_next = S_WAIT_DATA;
          end else begin
            req_addr_next = pc_reg;
            state_next    = S_WAIT_ADDR;
          end
        end
      end

      S_WAIT_ADDR: begin
        if (inst_sram_addr_ok) begin
          // Any redirect seen since the request went out dooms its data.
          discard_next = stale_reg | redirect;
          stale_next   = 1'b0;
          state_next   = S_WAIT_DATA;
        end else if (redirect) begin
          stale_next = 1'b1;
        end
      end

      S_WAIT_DATA: begin
        if (inst_sram_data_ok) begin
          if (discard_reg || redirect) begin
            discard_next = 1'b0;
            state_next   = S_REQ;
          end else begin
            buf_valid_next = 1'b1;
            buf_next       = inst_entry;
            pc_next        = pc_reg + 32'd4;
            state_next     = S_HOLD;
          end
        end else if (redirect) begin
          discard_next = 1'b1;
        end
      end

      S_HOLD: begin
        if (handoff || redirect) begin
          buf_valid_next = 1'b0;
          state_next     = S_REQ;
          if (issue) begin
            if (inst_sram_addr_ok) begin
              state_next = S_WAIT_DATA;
            end else begin
              req_addr_next = pc_reg;
              state_next    = S_WAIT_ADDR;
            end
          end
        end
      end

      default: begin
        state_next = S_REQ;
      end
    endcase

    // A redirect always retargets the PC and empties the buffer.
    if (redirect) begin
      pc_next        = redirect_pc;
      buf_valid_next = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_REQ;
      pc_reg        <= RESET_PC;
      req_addr_reg  <= RESET_PC;
      buf_valid_reg <= 1'b0;
      buf_reg       <= 75'h0;
      discard_reg   <= 1'b0;
      stale_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      req_addr_reg  <= req_addr_next;
      buf_valid_reg <= buf_valid_next;
      buf_reg       <= buf_next;
      discard_reg   <= discard_next;
      stale_reg     <= stale_next;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, basic fetch, stall, redirects,
// ADEF on a misaligned ertn target, and PC wrap-around.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        FpD_valid;
  logic [74:0] FpD_BUS;
  logic        pD_allowin;
  logic        pDD_fire;
  logic [32:0] predict_BUS;
  logic        predict_error;
  logic [31:0] br_correct_target;
  logic        ertn_flush;
  logic [31:0] era;
  logic        ex_en;
  logic [31:0] ex_entry;

  int total = 0;
  int bad   = 0;

  fetch_stage dut (
    .clk               (clk),
    .rst               (rst),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata),
    .FpD_valid         (FpD_valid),
    .FpD_BUS           (FpD_BUS),
    .pD_allowin        (pD_allowin),
    .pDD_fire          (pDD_fire),
    .predict_BUS       (predict_BUS),
    .predict_error     (predict_error),
    .br_correct_target (br_correct_target),
    .ertn_flush        (ertn_flush),
    .era               (era),
    .ex_en             (ex_en),
    .ex_entry          (ex_entry)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [74:0] obs, input logic [74:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-14s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [74:0] inst_bus(input logic [31:0] pc, input logic [31:0] inst);
    return {pc, inst, 1'b1, 1'b0, 8'h00, 1'b0};
  endfunction

  // Directed stimulus sequence.
  initial begin
    rst = 1'b1;
    inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b0;
    inst_sram_rdata = 32'h0;
    pD_allowin = 1'b0;
    pDD_fire = 1'b0;
    predict_BUS = 33'h0;
    predict_error = 1'b0;
    br_correct_target = 32'h0;
    ertn_flush = 1'b0;
    era = 32'h0;
    ex_en = 1'b0;
    ex_entry = 32'h0;

    repeat (3) tick();
    chk("rst_req", 75'(inst_sram_req), 75'(1'b0));
    chk("rst_valid", 75'(FpD_valid), 75'(1'b0));
    chk("rst_bus", FpD_BUS, 75'h0);
    rst = 1'b0;

    // 1: first fetch, addr_ok immediately, data one cycle later
    inst_sram_addr_ok = 1'b1;
    #1;
    chk("t1_req", 75'(inst_sram_req), 75'(1'b1));
    chk("t1_addr", 75'(inst_sram_addr), 75'(32'h1c000000));
    tick();
    inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata = 32'h02800c21;
    #1;
    chk("t1_wd_req", 75'(inst_sram_req), 75'(1'b0));
    chk("t1_wd_valid", 75'(FpD_valid), 75'(1'b0));
    tick();
    inst_sram_data_ok = 1'b0;
    #1;
    chk("t1_valid", 75'(FpD_valid), 75'(1'b1));
    chk("t1_bus", FpD_BUS, inst_bus(32'h1c000000, 32'h02800c21));

    // 2: preDecode stalls for five cycles
    for (int i = 0; i < 5; i++) begin
      chk("t2_valid", 75'(FpD_valid), 75'(1'b1));
      chk("t2_bus", FpD_BUS, inst_bus(32'h1c000000, 32'h02800c21));
      chk("t2_req", 75'(inst_sram_req), 75'(1'b0));
      tick();
    end
    pD_allowin = 1'b1;
    inst_sram_addr_ok = 1'b1;
    #1;
    chk("t2_req_go", 75'(inst_sram_req), 75'(1'b1));
    chk("t2_addr", 75'(inst_sram_addr), 75'(32'h1c000004));
    tick();
    pD_allowin = 1'b0;
    inst_sram_addr_ok = 1'b0;

    // 3: mispredict while waiting for data
    predict_error = 1'b1;
    br_correct_target = 32'h1c000100;
    #1;
    chk("t3_valid", 75'(FpD_valid), 75'(1'b0));
    chk("t3_req", 75'(inst_sram_req), 75'(1'b0));
    tick();
    predict_error = 1'b0;
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata = 32'hdeadbeef;
    tick();
    inst_sram_data_ok = 1'b0;
    #1;
    chk("t3_drop_valid", 75'(FpD_valid), 75'(1'b0));
    chk("t3_req2", 75'(inst_sram_req), 75'(1'b1));
    chk("t3_addr", 75'(inst_sram_addr), 75'(32'h1c000100));

    // 4: exception beats mispredict in the same cycle
    ex_en = 1'b1;
    ex_entry = 32'h1c008000;
    predict_error = 1'b1;
    br_correct_target = 32'h1c000200;
    #1;
    chk("t4_req_hold", 75'(inst_sram_req), 75'(1'b0));
    tick();
    ex_en = 1'b0;
    predict_error = 1'b0;
    #1;
    chk("t4_req", 75'(inst_sram_req), 75'(1'b1));
    chk("t4_addr", 75'(inst_sram_addr), 75'(32'h1c008000));
    tick();
    chk("t4_wa_req", 75'(inst_sram_req), 75'(1'b1));
    chk("t4_wa_addr", 75'(inst_sram_addr), 75'(32'h1c008000));
    inst_sram_addr_ok = 1'b1;
    tick();
    inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata = 32'h12345678;
    tick();
    inst_sram_data_ok = 1'b0;
    #1;
    chk("t4_bus", FpD_BUS, inst_bus(32'h1c008000, 32'h12345678));

    // 5: predict_taken held, redirect only once pDD_fire arrives
    predict_BUS = {1'b1, 32'h1c000040};
    for (int i = 0; i < 3; i++) begin
      chk("t5_valid", 75'(FpD_valid), 75'(1'b1));
      chk("t5_req", 75'(inst_sram_req), 75'(1'b0));
      tick();
    end
    pDD_fire = 1'b1;
    pD_allowin = 1'b1;
    #1;
    chk("t5_fire_req", 75'(inst_sram_req), 75'(1'b0));
    tick();
    pDD_fire = 1'b0;
    pD_allowin = 1'b0;
    #1;
    chk("t5_valid0", 75'(FpD_valid), 75'(1'b0));
    chk("t5_req2", 75'(inst_sram_req), 75'(1'b1));
    chk("t5_addr", 75'(inst_sram_addr), 75'(32'h1c000040));
    inst_sram_addr_ok = 1'b1;
    tick();
    inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata = 32'haaaa5555;
    tick();
    inst_sram_data_ok = 1'b0;
    #1;
    chk("t5_bus", FpD_BUS, inst_bus(32'h1c000040, 32'haaaa5555));
    predict_BUS = 33'h0;
    pD_allowin = 1'b1;
    #1;
    chk("t5_next_req", 75'(inst_sram_req), 75'(1'b1));
    chk("t5_next_addr", 75'(inst_sram_addr), 75'(32'h1c000044));
    tick();
    pD_allowin = 1'b0;

    // 6: ertn to a misaligned era while a request awaits addr_ok
    ertn_flush = 1'b1;
    era = 32'h1c000002;
    inst_sram_addr_ok = 1'b1;
    #1;
    chk("t6_req", 75'(inst_sram_req), 75'(1'b1));
    chk("t6_addr", 75'(inst_sram_addr), 75'(32'h1c000044));
    tick();
    ertn_flush = 1'b0;
    inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata = 32'hffffffff;
    #1;
    chk("t6_wd_req", 75'(inst_sram_req), 75'(1'b0));
    tick();
    inst_sram_data_ok = 1'b0;
    #1;
    chk("t6_drop_valid", 75'(FpD_valid), 75'(1'b0));
    chk("t6_no_req", 75'(inst_sram_req), 75'(1'b0));
    tick();
    chk("t6_valid", 75'(FpD_valid), 75'(1'b1));
    chk("t6_bus", FpD_BUS, {32'h1c000002, 32'h0, 1'b0, 1'b1, 8'h08, 1'b0});
    tick();
    chk("t6_stall_req", 75'(inst_sram_req), 75'(1'b0));
    chk("t6_stall_vld", 75'(FpD_valid), 75'(1'b1));

    // PC wrap: fetch at 32'hfffffffc, next address is 0
    ex_en = 1'b1;
    ex_entry = 32'hfffffffc;
    tick();
    ex_en = 1'b0;
    #1;
    chk("wrap_valid0", 75'(FpD_valid), 75'(1'b0));
    chk("wrap_addr", 75'(inst_sram_addr), 75'(32'hfffffffc));
    inst_sram_addr_ok = 1'b1;
    tick();
    inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata = 32'h0badf00d;
    tick();
    inst_sram_data_ok = 1'b0;
    #1;
    chk("wrap_bus", FpD_BUS, inst_bus(32'hfffffffc, 32'h0badf00d));
    pD_allowin = 1'b1;
    #1;
    chk("wrap_req", 75'(inst_sram_req), 75'(1'b1));
    chk("wrap_next", 75'(inst_sram_addr), 75'(32'h0));
    tick();
    pD_allowin = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
